mr_scoreboard: RTL and testbench

Parametrised register file plus pending-write scoreboard for the decode stage: combinational operand reads, per-register outstanding-write counters, and an outstanding-branch counter. It decides whether the instruction presented at issue can leave decode this cycle. It generalises the single-writeback, two-source, 2-bit-counter, one-branch scheme to N read ports, M writeback ports, configurable counter depth, multiple outstanding branches, optional writeback bypass and a pipeline flush.

---
 rtl/mr_scoreboard.sv | 183 ++++++++++++++++++
 tb/tb_mr_scoreboard.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mr_scoreboard.sv
// mr_scoreboard: decode-stage register file with a pending-write scoreboard.
// It provides combinational operand reads, a saturating outstanding-write
// count per register and an outstanding-branch count. From these it decides
// whether the instruction at issue may leave decode this cycle.
module mr_scoreboard #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWB    = 1,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned MAX_BR = 1,
  parameter int unsigned BYPASS = 0,
  localparam int unsigned RW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_ready,
  input  logic [NRD*RW-1:0]   rs_sel,
  input  logic [NRD-1:0]      rs_used,
  input  logic [RW-1:0]       rd,
  input  logic                rd_used,
  input  logic                is_branch,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic                stall,
  output logic                fire,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*RW-1:0]   wb_reg,
  input  logic [NWB*XLEN-1:0] wb_val,
  input  logic                br_done,
  input  logic                flush
);

  localparam int unsigned      BW      = (MAX_BR < 1) ? 1 : $clog2(MAX_BR + 1);
  localparam int unsigned      DW      = $clog2(NWB + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [BW-1:0]    BR_MAX  = BW'(MAX_BR);

  logic [XLEN-1:0]  regs      [NREGS];
  logic [CNT_W-1:0] pend      [NREGS];
  logic [CNT_W-1:0] pend_next [NREGS];
  logic [DW-1:0]    wb_cnt    [NREGS];
  logic [BW-1:0]    brcnt;
  logic [BW-1:0]    brcnt_next;

  logic [RW-1:0]    sel_a [NRD];
  logic [RW-1:0]    wbr_a [NWB];
  logic [XLEN-1:0]  wbd_a [NWB];
  logic [NWB-1:0]   wb_live;

  logic src_haz;
  logic dst_sat;
  logic br_haz;
  logic hazard;
  logic busy;

  // Unpack the flat port vectors. A writeback to x0 is treated as absent.
  always_comb begin
    for (int unsigned i = 0; i < NRD; i++) begin
      sel_a[i] = rs_sel[i*RW +: RW];
    end
    for (int unsigned p = 0; p < NWB; p++) begin
      wbr_a[p]   = wb_reg[p*RW +: RW];
      wbd_a[p]   = wb_val[p*XLEN +: XLEN];
      wb_live[p] = wb_valid[p] && (wbr_a[p] != '0);
    end
  end

  // Count the writebacks that land on each register this cycle.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      wb_cnt[r] = '0;
      for (int unsigned p = 0; p < NWB; p++) begin
        if (wb_live[p] && (wbr_a[p] == RW'(r))) begin
          wb_cnt[r] = wb_cnt[r] + DW'(1);
        end
      end
    end
  end

  // Operand read: x0 is hard zero. The optional bypass scans the ports in
  // ascending order so that the highest matching port wins.
  always_comb begin
    rs_data = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (sel_a[i] != '0) begin
        rs_data[i*XLEN +: XLEN] = regs[sel_a[i]];
      end
      if (BYPASS != 0) begin
        for (int unsigned p = 0; p < NWB; p++) begin
          if (wb_live[p] && (wbr_a[p] == sel_a[i])) begin
            rs_data[i*XLEN +: XLEN] = wbd_a[p];
          end
        end
      end
    end
  end

  // Issue decision: source RAW, destination counter saturation, branch shadow.
  always_comb begin
    src_haz = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (rs_used[i] && (sel_a[i] != '0) && (pend[sel_a[i]] != '0)) begin
        // A single outstanding write that is landing right now is forwarded.
        if (!((BYPASS != 0) && (pend[sel_a[i]] == CNT_W'(1)) &&
              (wb_cnt[sel_a[i]] != '0))) begin
          src_haz = 1'b1;
        end
      end
    end
    dst_sat = rd_used && (rd != '0) && (pend[rd] == CNT_MAX) && (wb_cnt[rd] == '0);
    br_haz  = (brcnt != '0) || (is_branch && (brcnt == BR_MAX));
    hazard  = src_haz || dst_sat || br_haz;
    stall   = rst && issue_valid && hazard;
    fire    = rst && issue_valid && issue_ready && !hazard && !flush;
  end

  // Next counter values: one net step of +issue -writebacks, floored at zero.
  always_comb begin : next_counts
    int net;
    for (int unsigned r = 0; r < NREGS; r++) begin
      net = int'(pend[r]) - int'(wb_cnt[r]);
      if (fire && rd_used && (rd != '0) && (rd == RW'(r))) begin
        net = net + 1;
      end
      pend_next[r] = (net < 0) ? '0 : CNT_W'(net);
    end
    net = int'(brcnt) - (br_done ? 1 : 0);
    if (fire && is_branch) begin
      net = net + 1;
    end
    brcnt_next = (net < 0) ? '0 : BW'(net);
  end

  // State update: reset clears everything, flush clears only the tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
      brcnt <= '0;
    end else begin
      for (int unsigned p = 0; p < NWB; p++) begin
        if (wb_live[p]) begin
          regs[wbr_a[p]] <= wbd_a[p];
        end
      end
      for (int unsigned r = 0; r < NREGS; r++) begin
        pend[r] <= flush ? '0 : pend_next[r];
      end
      brcnt <= flush ? '0 : brcnt_next;
    end
  end

  // Anything still in flight (used to tell a clean reset from a mid-stream one).
  always_comb begin
    busy = (brcnt != '0);
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (pend[r] != '0) begin
        busy = 1'b1;
      end
    end
  end

  // Simulation checks. A writeback to an idle register becomes legal once
  // tracking has been thrown away by a flush or by a reset taken while busy.
  logic discarded = 1'b0;
  always_ff @(posedge clk) begin
    if ((!rst && busy) || (rst && flush)) begin
      discarded <= 1'b1;
    end
    if (rst) begin
      for (int unsigned p = 0; p < NWB; p++) begin
        assert (!wb_live[p] || (pend[wbr_a[p]] != '0) || discarded)
          else $error("mr_scoreboard: writeback to x%0d with nothing pending", wbr_a[p]);
      end
      assert (!br_done || (brcnt != '0))
        else $error("mr_scoreboard: br_done with no branch in flight");
    end
  end

endmodule

// File: tb/tb_mr_scoreboard.sv
// tb_mr_scoreboard: directed scenarios followed by a randomized run, all
// checked against a behavioural scoreboard model kept in integer arrays.
module tb_mr_scoreboard;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned NRD    = 2;
  localparam int unsigned NWB    = 2;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned MAX_BR = 1;
  localparam int unsigned BYPASS = 1;
  localparam int unsigned RW     = 5;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, issue_valid, issue_ready, rd_used, is_branch, br_done, flush;
  logic [RW-1:0]   sel  [NRD];
  logic [NRD-1:0]  rs_used;
  logic [RW-1:0]   rd;
  logic [NWB-1:0]  wb_valid;
  logic [RW-1:0]   wreg [NWB];
  logic [XLEN-1:0] wval [NWB];

  logic [NRD*RW-1:0]   rs_sel_v;
  logic [NWB*RW-1:0]   wb_reg_v;
  logic [NWB*XLEN-1:0] wb_val_v;
  logic [NRD*XLEN-1:0] rs_data;
  logic                stall, fire;

  always_comb begin
    rs_sel_v = '0;
    for (int i = 0; i < NRD; i++) rs_sel_v[i*RW +: RW] = sel[i];
  end

  always_comb begin
    wb_reg_v = '0;
    wb_val_v = '0;
    for (int p = 0; p < NWB; p++) begin
      wb_reg_v[p*RW +: RW]     = wreg[p];
      wb_val_v[p*XLEN +: XLEN] = wval[p];
    end
  end

  mr_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWB(NWB),
    .CNT_W(CNT_W), .MAX_BR(MAX_BR), .BYPASS(BYPASS)
  ) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs_sel(rs_sel_v), .rs_used(rs_used), .rd(rd), .rd_used(rd_used),
    .is_branch(is_branch), .rs_data(rs_data), .stall(stall), .fire(fire),
    .wb_valid(wb_valid), .wb_reg(wb_reg_v), .wb_val(wb_val_v),
    .br_done(br_done), .flush(flush)
  );

  // Reference model state.
  logic [XLEN-1:0] m_regs [NREGS];
  int              m_pend [NREGS];
  int              m_br;
  logic            exp_stall, exp_fire;
  logic [XLEN-1:0] exp_rs [NRD];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void model_eval();
    bit blocked;
    blocked = (m_br > 0) || (is_branch && m_br >= MAX_BR);
    for (int i = 0; i < NRD; i++) begin
      int s;
      bit landing;
      s = int'(sel[i]);
      exp_rs[i] = (s == 0) ? '0 : m_regs[s];
      landing = 1'b0;
      for (int p = 0; p < NWB; p++) begin
        if (wb_valid[p] && wreg[p] == sel[i] && s != 0) begin
          landing = 1'b1;
          if (BYPASS != 0) exp_rs[i] = wval[p];
        end
      end
      if (rs_used[i] && s != 0 && m_pend[s] > 0 &&
          !(BYPASS != 0 && m_pend[s] == 1 && landing)) blocked = 1'b1;
    end
    if (rd_used && rd != 0 && m_pend[rd] == CMAX) begin
      bit rdwb;
      rdwb = 1'b0;
      for (int p = 0; p < NWB; p++) if (wb_valid[p] && wreg[p] == rd) rdwb = 1'b1;
      if (!rdwb) blocked = 1'b1;
    end
    exp_stall = rst && issue_valid && blocked;
    exp_fire  = rst && issue_valid && issue_ready && !blocked && !flush;
  endfunction

  function automatic void model_commit();
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_pend[r] = 0;
      end
      m_br = 0;
      return;
    end
    if (exp_fire && rd_used && rd != 0) m_pend[rd]++;
    if (exp_fire && is_branch) m_br++;
    for (int p = 0; p < NWB; p++) begin
      if (wb_valid[p] && wreg[p] != 0) begin
        m_regs[wreg[p]] = wval[p];
        if (m_pend[wreg[p]] > 0) m_pend[wreg[p]]--;
      end
    end
    if (br_done && m_br > 0) m_br--;
    if (flush) begin
      for (int r = 0; r < NREGS; r++) m_pend[r] = 0;
      m_br = 0;
    end
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_ready = 1'b1; rd = '0; rd_used = 1'b0;
    is_branch = 1'b0; rs_used = '0; br_done = 1'b0; flush = 1'b0;
    wb_valid = '0;
    for (int i = 0; i < NRD; i++) sel[i] = '0;
    for (int p = 0; p < NWB; p++) begin wreg[p] = '0; wval[p] = '0; end
  endtask

  task automatic test_reset();
    rst = 1'b0; idle();
    repeat (3) tick();
    issue_valid = 1'b1; rd = 5; rd_used = 1'b1; sel[0] = 5; rs_used = 2'b01; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (fire !== 1'b0) begin n_bad++; $display("FAIL reset_fire: got %b want 0", fire); end
    tick();
    rst = 1'b1; idle(); sel[0] = 5; sel[1] = 31; #1;
    n_cmp++; if (rs_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL reset_x5: got %h want 0", rs_data[31:0]); end
    n_cmp++; if (rs_data[63:32] !== 32'h0) begin n_bad++; $display("FAIL reset_x31: got %h want 0", rs_data[63:32]); end
  endtask

  task automatic test_raw();
    idle(); issue_valid = 1'b1; rd = 5; rd_used = 1'b1; #1;
    n_cmp++; if (fire !== 1'b1) begin n_bad++; $display("FAIL raw_issue_fire: got %b want 1", fire); end
    tick();
    idle(); issue_valid = 1'b1; sel[0] = 5; rs_used = 2'b01; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL raw_stall: got %b want 1", stall); end
    n_cmp++; if (fire !== 1'b0) begin n_bad++; $display("FAIL raw_nofire: got %b want 0", fire); end
    tick();
    idle(); wb_valid = 2'b01; wreg[0] = 5; wval[0] = 32'h1234; #1; tick();
    idle(); issue_valid = 1'b1; sel[0] = 5; sel[1] = 5; rs_used = 2'b01; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL raw_release: got %b want 0", stall); end
    n_cmp++; if (fire !== 1'b1) begin n_bad++; $display("FAIL raw_fire: got %b want 1", fire); end
    n_cmp++; if (rs_data[31:0] !== 32'h1234) begin n_bad++; $display("FAIL raw_data0: got %h want 1234", rs_data[31:0]); end
    n_cmp++; if (rs_data[63:32] !== 32'h1234) begin n_bad++; $display("FAIL raw_data1: got %h want 1234", rs_data[63:32]); end
    tick();
  endtask

  task automatic test_bypass();
    idle(); issue_valid = 1'b1; rd = 7; rd_used = 1'b1; #1; tick();
    idle(); issue_valid = 1'b1; sel[1] = 7; rs_used = 2'b10;
    wb_valid = 2'b01; wreg[0] = 7; wval[0] = 32'hAA; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL byp_stall: got %b want 0", stall); end
    n_cmp++; if (fire !== 1'b1) begin n_bad++; $display("FAIL byp_fire: got %b want 1", fire); end
    n_cmp++; if (rs_data[63:32] !== 32'hAA) begin n_bad++; $display("FAIL byp_data: got %h want aa", rs_data[63:32]); end
    tick();
    idle(); issue_valid = 1'b1; rd = 7; rd_used = 1'b1; #1; tick(); tick();
    idle(); issue_valid = 1'b1; sel[0] = 7; rs_used = 2'b01;
    wb_valid = 2'b10; wreg[1] = 7; wval[1] = 32'hBB; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL byp_two_stall: got %b want 1", stall); end
    n_cmp++; if (rs_data[31:0] !== 32'hBB) begin n_bad++; $display("FAIL byp_two_data: got %h want bb", rs_data[31:0]); end
    tick();
    idle(); wb_valid = 2'b01; wreg[0] = 7; wval[0] = 32'hCC; #1; tick();
  endtask

  task automatic test_saturation();
    idle(); issue_valid = 1'b1; rd = 3; rd_used = 1'b1; #1;
    tick(); tick(); tick();
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sat_stall: got %b want 1", stall); end
    wb_valid = 2'b01; wreg[0] = 3; wval[0] = 32'h33; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL sat_wb_stall: got %b want 0", stall); end
    n_cmp++; if (fire !== 1'b1) begin n_bad++; $display("FAIL sat_wb_fire: got %b want 1", fire); end
    tick();
    wb_valid = '0; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sat_still_full: got %b want 1", stall); end
    idle(); wb_valid = 2'b11; wreg[0] = 3; wreg[1] = 3; wval[0] = 32'h31; wval[1] = 32'h32; #1; tick();
    idle(); wb_valid = 2'b01; wreg[0] = 3; wval[0] = 32'h35; #1; tick();
    idle(); issue_valid = 1'b1; sel[0] = 3; rs_used = 2'b01; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL sat_drained: got %b want 0", stall); end
    n_cmp++; if (rs_data[31:0] !== 32'h35) begin n_bad++; $display("FAIL sat_data: got %h want 35", rs_data[31:0]); end
    tick();
  endtask

  task automatic test_dual_wb();
    idle(); issue_valid = 1'b1; rd = 9; rd_used = 1'b1; #1; tick(); tick();
    idle(); sel[0] = 9; wb_valid = 2'b11; wreg[0] = 9; wreg[1] = 9;
    wval[0] = 32'h1; wval[1] = 32'h2; #1;
    n_cmp++; if (rs_data[31:0] !== 32'h2) begin n_bad++; $display("FAIL dual_bypass: got %h want 2", rs_data[31:0]); end
    tick();
    idle(); issue_valid = 1'b1; sel[1] = 9; rs_used = 2'b10; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL dual_pend_zero: got %b want 0", stall); end
    n_cmp++; if (rs_data[63:32] !== 32'h2) begin n_bad++; $display("FAIL dual_data: got %h want 2", rs_data[63:32]); end
    tick();
  endtask

  task automatic test_branch();
    idle(); issue_valid = 1'b1; is_branch = 1'b1; #1;
    n_cmp++; if (fire !== 1'b1) begin n_bad++; $display("FAIL br_fire: got %b want 1", fire); end
    tick();
    idle(); issue_valid = 1'b1; rd = 12; rd_used = 1'b1; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL br_shadow: got %b want 1", stall); end
    n_cmp++; if (fire !== 1'b0) begin n_bad++; $display("FAIL br_shadow_fire: got %b want 0", fire); end
    is_branch = 1'b1; rd_used = 1'b0; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL br_second: got %b want 1", stall); end
    tick();
    idle(); br_done = 1'b1; #1; tick();
    idle(); issue_valid = 1'b1; issue_ready = 1'b0; rd = 12; rd_used = 1'b1; #1;
    n_cmp++; if (fire !== 1'b0) begin n_bad++; $display("FAIL br_not_ready: got %b want 0", fire); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL br_not_ready_stall: got %b want 0", stall); end
    issue_ready = 1'b1; #1;
    n_cmp++; if (fire !== 1'b1) begin n_bad++; $display("FAIL br_resolved: got %b want 1", fire); end
    tick();
    idle(); wb_valid = 2'b01; wreg[0] = 12; wval[0] = 32'h12; #1; tick();
  endtask

  task automatic test_flush();
    idle(); issue_valid = 1'b1; rd = 4; rd_used = 1'b1; #1; tick(); tick();
    idle(); issue_valid = 1'b1; is_branch = 1'b1; #1; tick();
    idle(); issue_valid = 1'b1; sel[0] = 4; rs_used = 2'b01; flush = 1'b1;
    wb_valid = 2'b01; wreg[0] = 4; wval[0] = 32'h44; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL flush_cycle_stall: got %b want 1", stall); end
    n_cmp++; if (fire !== 1'b0) begin n_bad++; $display("FAIL flush_cycle_fire: got %b want 0", fire); end
    tick();
    idle(); issue_valid = 1'b1; sel[0] = 4; rs_used = 2'b01; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_cleared: got %b want 0", stall); end
    n_cmp++; if (fire !== 1'b1) begin n_bad++; $display("FAIL flush_after_fire: got %b want 1", fire); end
    n_cmp++; if (rs_data[31:0] !== 32'h44) begin n_bad++; $display("FAIL flush_wb_data: got %h want 44", rs_data[31:0]); end
    tick();
    idle(); issue_valid = 1'b1; flush = 1'b1; #1;
    n_cmp++; if (fire !== 1'b0) begin n_bad++; $display("FAIL flush_suppress: got %b want 0", fire); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_no_stall: got %b want 0", stall); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle(); issue_valid = 1'b1; rd = 6; rd_used = 1'b1; #1; tick();
    rst = 1'b0; idle(); issue_valid = 1'b1; sel[0] = 6; rs_used = 2'b01; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mid_rst_stall: got %b want 0", stall); end
    n_cmp++; if (fire !== 1'b0) begin n_bad++; $display("FAIL mid_rst_fire: got %b want 0", fire); end
    tick();
    rst = 1'b1; idle(); issue_valid = 1'b1; sel[0] = 4; sel[1] = 6; rs_used = 2'b11; #1;
    n_cmp++; if (rs_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL mid_rst_zeroed: got %h want 0", rs_data[31:0]); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mid_rst_pend_gone: got %b want 0", stall); end
    tick();
    idle(); wb_valid = 2'b10; wreg[1] = 6; wval[1] = 32'h66; #1; tick();
    idle(); issue_valid = 1'b1; sel[0] = 6; rs_used = 2'b01; rd = 6; rd_used = 1'b1; #1;
    n_cmp++; if (rs_data[31:0] !== 32'h66) begin n_bad++; $display("FAIL mid_rst_late_wb: got %h want 66", rs_data[31:0]); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mid_rst_clamp: got %b want 0", stall); end
    tick();
    idle(); wb_valid = 2'b01; wreg[0] = 6; wval[0] = 32'h67; #1; tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      idle();
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_ready = ($urandom_range(0, 5) != 0);
      for (int i = 0; i < NRD; i++) begin
        sel[i]     = RW'($urandom_range(0, 7));
        rs_used[i] = 1'($urandom_range(0, 1));
      end
      rd        = RW'($urandom_range(0, 7));
      rd_used   = 1'($urandom_range(0, 1));
      is_branch = ($urandom_range(0, 9) == 0);
      for (int p = 0; p < NWB; p++) begin
        int pick;
        pick = int'($urandom_range(1, 7));
        if (m_pend[pick] > 0 && $urandom_range(0, 1) == 1) begin
          wb_valid[p] = 1'b1;
          wreg[p]     = RW'(pick);
          wval[p]     = $urandom();
        end
      end
      br_done = (m_br > 0) && ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 39) == 0);
      #1;
      model_eval();
      n_cmp++; if (stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, stall, exp_stall); end
      n_cmp++; if (fire !== exp_fire) begin n_bad++; $display("FAIL rnd_fire c=%0d: got %b want %b", c, fire, exp_fire); end
      for (int i = 0; i < NRD; i++) begin
        n_cmp++;
        if (rs_data[i*XLEN +: XLEN] !== exp_rs[i]) begin
          n_bad++;
          $display("FAIL rnd_data c=%0d port%0d: got %h want %h", c, i, rs_data[i*XLEN +: XLEN], exp_rs[i]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_bypass();
    test_saturation();
    test_dual_wb();
    test_branch();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
